i2s_rx: RTL and testbench

- I2S receiver (slave) for the Bluetooth audio module's serial stream.
- Oversamples I2S_sclk, I2S_ws and I2S_data on the 50 MHz system clock and deserializes 24-bit left/right samples. Samples are MSB first, one-bit delay after each ws edge, 32-bit slots.
- Presents each stereo sample pair with a single-cycle vld strobe to the EQ engine, which consumes the upper 16 bits.
- Adds framing-error detection and resynchronization.

---
 rtl/i2s_rx_pkg.sv | 18 +
 rtl/i2s_sync_edge.sv | 45 ++++
 rtl/i2s_rx.sv | 135 +++++++++++++
 tb/tb_i2s_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_rx_pkg : shared types and constants for the I2S slave receiver    |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package i2s_rx_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W     = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_sync_edge : N-stage synchronizers for sclk/ws/data plus the sclk  |
// |                 rising-edge detector; all outputs from the last stage |
// | Revision      : 1.0  initial release                                 |
// +----------------------------------------------------------------------+
module i2s_sync_edge #(
  parameter int SYNC_STG = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i2s_sclk,
  input  logic i2s_ws,
  input  logic i2s_data,
  output logic sclk_rise,
  output logic ws_s,
  output logic data_s
);

  logic [SYNC_STG-1:0] r_sclk_sync;
  logic [SYNC_STG-1:0] r_ws_sync;
  logic [SYNC_STG-1:0] r_data_sync;
  logic                r_sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ws_sync   <= '0;
      r_data_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], i2s_sclk};
      r_ws_sync   <= {r_ws_sync[SYNC_STG-2:0], i2s_ws};
      r_data_sync <= {r_data_sync[SYNC_STG-2:0], i2s_data};
      r_sclk_prev <= r_sclk_sync[SYNC_STG-1];
    end
  end

  // ws/data are taken from the same depth as sclk so they are sampled coherently
  assign sclk_rise = r_sclk_sync[SYNC_STG-1] & ~r_sclk_prev;
  assign ws_s      = r_ws_sync[SYNC_STG-1];
  assign data_s    = r_data_sync[SYNC_STG-1];

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_rx   : I2S slave receiver, 24-bit stereo capture with framing     |
// |            error detection and resynchronization                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SYNC_STG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I2S_sclk,
  input  logic              I2S_ws,
  input  logic              I2S_data,
  output logic [DATA_W-1:0] lft_chnnl,
  output logic [DATA_W-1:0] rght_chnnl,
  output logic              vld,
  output logic              sync_err
);

  localparam logic [5:0] c_CNT_FULL = 6'(DATA_W);
  localparam logic [5:0] c_CNT_SAT  = 6'(DATA_W + 1);

  logic              w_sclk_rise;
  logic              w_ws_s;
  logic              w_data_s;
  logic              w_ws_chg;
  logic              w_shift_en;
  logic [5:0]        w_cnt_nxt;
  logic [DATA_W-1:0] w_shreg_nxt;

  state_t            r_state;
  logic [5:0]        r_cnt;
  logic              r_ws_q;
  logic              r_done;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_lft_hold;

  i2s_sync_edge #(
    .SYNC_STG (SYNC_STG)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_sclk  (I2S_sclk),
    .i2s_ws    (I2S_ws),
    .i2s_data  (I2S_data),
    .sclk_rise (w_sclk_rise),
    .ws_s      (w_ws_s),
    .data_s    (w_data_s)
  );

  assign w_ws_chg    = w_sclk_rise & (w_ws_s != r_ws_q);
  assign w_shreg_nxt = {r_shreg[DATA_W-2:0], w_data_s};

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_ws_chg)
      w_cnt_nxt = 6'd0;
    else if (r_cnt < c_CNT_SAT)
      w_cnt_nxt = r_cnt + 6'd1;
  end

  // The ws-change rise carries the delay bit; only counts 1..DATA_W carry sample bits
  assign w_shift_en = w_sclk_rise && !w_ws_chg && (r_state != SYNC) &&
                      (w_cnt_nxt != 6'd0) && (w_cnt_nxt <= c_CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SYNC;
      r_cnt      <= 6'd0;
      r_ws_q     <= 1'b1;
      r_done     <= 1'b0;
      r_shreg    <= '0;
      r_lft_hold <= '0;
      lft_chnnl  <= '0;
      rght_chnnl <= '0;
      vld        <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      vld      <= 1'b0;
      sync_err <= 1'b0;
      r_done   <= 1'b0;

      if (r_done) begin
        lft_chnnl  <= r_lft_hold;
        rght_chnnl <= r_shreg;
        vld        <= 1'b1;
      end

      if (w_sclk_rise) begin
        r_ws_q <= w_ws_s;
        r_cnt  <= w_cnt_nxt;
        if (w_shift_en)
          r_shreg <= w_shreg_nxt;

        case (r_state)
          SYNC: begin
            if (w_ws_chg && !w_ws_s)
              r_state <= LEFT;
          end
          LEFT: begin
            if (w_ws_chg) begin
              if (r_cnt >= c_CNT_FULL) begin
                r_state <= RIGHT;
              end else begin
                sync_err <= 1'b1;
                r_state  <= SYNC;
              end
            end else if (w_shift_en && (w_cnt_nxt == c_CNT_FULL)) begin
              r_lft_hold <= w_shreg_nxt;
            end
          end
          RIGHT: begin
            if (w_ws_chg) begin
              if (r_cnt >= c_CNT_FULL) begin
                r_state <= LEFT;
              end else begin
                sync_err <= 1'b1;
                r_state  <= SYNC;
              end
            end else if (w_shift_en && (w_cnt_nxt == c_CNT_FULL)) begin
              r_done <= 1'b1;
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2s_rx : scoreboard bench for i2s_rx                               |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_i2s_rx;
  import i2s_rx_pkg::*;

  localparam int DW   = DATA_W_DEF;
  localparam int STG  = 3;
  localparam int HALF = 8;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          I2S_sclk;
  logic          I2S_ws;
  logic          I2S_data;
  logic [DW-1:0] lft_chnnl;
  logic [DW-1:0] rght_chnnl;
  logic          vld;
  logic          sync_err;

  pair_t         exp_q[$];
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;
  int cyc = 0, n_vec = 0, n_err = 0;
  int vld_cnt = 0, serr_cnt = 0, vld_cyc = 0, last_data_rise = 0;
  bit spacing_on = 1'b0, have_prev = 1'b0;

  i2s_rx #(
    .DATA_W   (DW),
    .SYNC_STG (STG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I2S_sclk   (I2S_sclk),
    .I2S_ws     (I2S_ws),
    .I2S_data   (I2S_data),
    .lft_chnnl  (lft_chnnl),
    .rght_chnnl (rght_chnnl),
    .vld        (vld),
    .sync_err   (sync_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pops an expected pair per vld and checks the held pair every cycle
  always @(negedge clk) begin
    pair_t p;
    if (!rst_n) begin
      exp_l = '0;
      exp_r = '0;
    end else begin
      if (vld === 1'b1) begin
        vld_cnt++;
        if (spacing_on && have_prev) begin
          n_vec++;
          if (cyc - vld_cyc != 64 * 2 * HALF) begin
            n_err++;
            $display("FAIL vld_spacing: got %0d clks, required %0d", cyc - vld_cyc, 64 * 2 * HALF);
          end
        end
        have_prev = 1'b1;
        vld_cyc   = cyc;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_vld: vld=1 at cycle %0d, required no vld", cyc);
        end else begin
          p     = exp_q.pop_front();
          exp_l = p.l;
          exp_r = p.r;
        end
      end
      if (sync_err === 1'b1) serr_cnt++;
    end
    n_vec++;
    if (lft_chnnl !== exp_l || rght_chnnl !== exp_r) begin
      n_err++;
      $display("FAIL pair_hold: lft=%h rght=%h, required lft=%h rght=%h at cycle %0d",
               lft_chnnl, rght_chnnl, exp_l, exp_r, cyc);
    end
  end

  // Bit i of a slot: 0 is the delay bit, 1..DW carry MSB..LSB, the rest is random padding
  task automatic send_bits(input logic w, input logic [DW-1:0] val, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic d;
      d = (i >= 1 && i <= DW) ? val[DW-i] : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      I2S_sclk = 1'b0;
      I2S_ws   = w;
      I2S_data = d;
      repeat (HALF) @(posedge clk);
      #1 I2S_sclk = 1'b1;
      if (w && i == DW) last_data_rise = cyc;
      repeat (HALF - 1) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot, input bit expect_vld);
    if (expect_vld) exp_q.push_back({l, r});
    send_bits(1'b0, l, 0, slot - 1);
    send_bits(1'b1, r, 0, slot - 1);
  endtask

  task automatic test_reset();
    int v0;
    rst_n = 1'b0; I2S_sclk = 1'b0; I2S_ws = 1'b1; I2S_data = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_vec += 4;
    if (lft_chnnl !== '0)  begin n_err++; $display("FAIL reset_lft: got %h, required 0", lft_chnnl); end
    if (rght_chnnl !== '0) begin n_err++; $display("FAIL reset_rght: got %h, required 0", rght_chnnl); end
    if (vld !== 1'b0)      begin n_err++; $display("FAIL reset_vld: got %b, required 0", vld); end
    if (sync_err !== 1'b0) begin n_err++; $display("FAIL reset_sync_err: got %b, required 0", sync_err); end
    @(posedge clk); #1 rst_n = 1'b1;
    v0 = vld_cnt;
    send_bits(1'b1, DW'($urandom), 16, 31);
    n_vec++;
    if (vld_cnt != v0) begin n_err++; $display("FAIL reset_no_early_vld: got %0d vld, required 0", vld_cnt - v0); end
    send_frame(24'h3C5A69, 24'hC3A596, SLOT_W, 1'b1);
    n_vec++;
    if (vld_cnt - v0 != 1) begin n_err++; $display("FAIL reset_first_frame: got %0d vld, required 1", vld_cnt - v0); end
  endtask

  task automatic test_basic();
    int v0, s0;
    v0 = vld_cnt; s0 = serr_cnt;
    send_frame(24'h7FFFFF, 24'h800001, SLOT_W, 1'b1);
    n_vec += 3;
    if (vld_cnt - v0 != 1)  begin n_err++; $display("FAIL basic_vld_count: got %0d, required 1", vld_cnt - v0); end
    if (serr_cnt != s0)     begin n_err++; $display("FAIL basic_sync_err: got %0d, required 0", serr_cnt - s0); end
    if (exp_q.size() != 0)  begin n_err++; $display("FAIL basic_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int v0, s0;
    logic [DW-1:0] l;
    v0 = vld_cnt; s0 = serr_cnt;
    have_prev  = 1'b0;
    spacing_on = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      l = DW'(n) * 24'h010101;
      send_frame(l, ~l, SLOT_W, 1'b1);
    end
    spacing_on = 1'b0;
    n_vec += 3;
    if (vld_cnt - v0 != 10) begin n_err++; $display("FAIL b2b_vld_count: got %0d, required 10", vld_cnt - v0); end
    if (serr_cnt != s0)     begin n_err++; $display("FAIL b2b_sync_err: got %0d, required 0", serr_cnt - s0); end
    if (exp_q.size() != 0)  begin n_err++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_early_ws();
    int v0, s0;
    v0 = vld_cnt; s0 = serr_cnt;
    send_bits(1'b0, 24'hFFFFFF, 0, 12);
    send_bits(1'b1, DW'($urandom), 0, SLOT_W - 1);
    n_vec += 2;
    if (serr_cnt - s0 != 1) begin n_err++; $display("FAIL early_ws_sync_err: got %0d, required 1", serr_cnt - s0); end
    if (vld_cnt != v0)      begin n_err++; $display("FAIL early_ws_no_vld: got %0d, required 0", vld_cnt - v0); end
    send_frame(24'hA5A5A5, 24'h5A5A5A, SLOT_W, 1'b1);
    n_vec += 3;
    if (vld_cnt - v0 != 1)  begin n_err++; $display("FAIL early_ws_recover: got %0d vld, required 1", vld_cnt - v0); end
    if (serr_cnt - s0 != 1) begin n_err++; $display("FAIL early_ws_serr_total: got %0d, required 1", serr_cnt - s0); end
    if (exp_q.size() != 0)  begin n_err++; $display("FAIL early_ws_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int v0, s0;
    v0 = vld_cnt; s0 = serr_cnt;
    send_bits(1'b0, 24'h123456, 0, 12);
    @(posedge clk); #1;
    I2S_sclk = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_vec++;
    if (lft_chnnl !== '0 || rght_chnnl !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async: lft=%h rght=%h, required 0/0", lft_chnnl, rght_chnnl);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_bits(1'b0, 24'h123456, 13, SLOT_W - 1);
    send_bits(1'b1, 24'h654321, 0, SLOT_W - 1);
    n_vec += 2;
    if (vld_cnt != v0)      begin n_err++; $display("FAIL mid_reset_no_vld: got %0d, required 0", vld_cnt - v0); end
    if (serr_cnt - s0 != 1) begin n_err++; $display("FAIL mid_reset_sync_err: got %0d, required 1", serr_cnt - s0); end
    send_frame(24'h0F0F0F, 24'hF0F0F0, SLOT_W, 1'b1);
    n_vec += 2;
    if (vld_cnt - v0 != 1)  begin n_err++; $display("FAIL mid_reset_recover: got %0d vld, required 1", vld_cnt - v0); end
    if (exp_q.size() != 0)  begin n_err++; $display("FAIL mid_reset_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_slot24();
    int v0, s0;
    v0 = vld_cnt; s0 = serr_cnt;
    send_frame(24'h9E3779, 24'h6A09E6, DW + 1, 1'b1);
    n_vec++;
    if (vld_cyc != last_data_rise + STG + 2) begin
      n_err++;
      $display("FAIL slot24_latency: vld at %0d, required %0d", vld_cyc, last_data_rise + STG + 2);
    end
    send_frame(24'h13579B, 24'hECA864, DW + 1, 1'b1);
    n_vec++;
    if (vld_cyc != last_data_rise + STG + 2) begin
      n_err++;
      $display("FAIL slot24_latency2: vld at %0d, required %0d", vld_cyc, last_data_rise + STG + 2);
    end
    repeat (40) @(posedge clk);
    n_vec += 3;
    if (vld_cnt - v0 != 2)  begin n_err++; $display("FAIL slot24_vld_count: got %0d, required 2", vld_cnt - v0); end
    if (serr_cnt != s0)     begin n_err++; $display("FAIL slot24_sync_err: got %0d, required 0", serr_cnt - s0); end
    if (exp_q.size() != 0)  begin n_err++; $display("FAIL slot24_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_early_ws();
    test_reset_mid();
    test_slot24();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
